// File: rtl/dac_sequencer.sv
// -----------------------------------------------------------------------------
// dac_sequencer
//
// Upstream control stage for the SPI DAC driver. A free-running tick counter
// starts a sweep every PERIOD cycles; each sweep writes one sample to every
// channel whose bit is set in chan_mask (latched at sweep start). Each
// channel's sample is an independent 12-bit sawtooth ramp that advances by
// `step` after every completed write. Only one write is in flight at a time.
//
// Optional feature (compile-time macro DAC_SEQ_TIMEOUT_EN):
//   defined   - a wait counter bounds WAIT_DONE to TIMEOUT cycles. On expiry,
//               error is set and the sweep is abandoned.
//   undefined - WAIT_DONE waits indefinitely and error is tied low.
//
// Ports:
//   CLK50MHZ   in   1   system clock, rising edge
//   RST        in   1   asynchronous active-low reset
//   enable     in   1   run sweeps while high; low clears overrun/error
//   chan_mask  in   4   bit n set = channel n written each sweep
//   step       in  12   ramp increment, sampled when a write completes
//   data       out 12   sample for the driver
//   address    out  4   channel number 0..3
//   command    out  4   CMD nibble, loaded with every write
//   dactrig    out  1   one-cycle start pulse to the driver
//   dacdone    in   1   one-cycle completion pulse from the driver
//   busy       out  1   high from the trig cycle until the sweep ends
//   overrun    out  1   sticky: a tick arrived while a sweep was active
//   error      out  1   sticky: dacdone timeout (zero without the macro)
//   state_dbg  out  3   current FSM state encoding (IDLE=0 .. ADVANCE=4)
// -----------------------------------------------------------------------------
module dac_sequencer #(
    parameter int unsigned PERIOD  = 5000,
    parameter logic [3:0]  CMD     = 4'b0011,
    parameter int unsigned TIMEOUT = 2048
) (
    input  logic        CLK50MHZ,
    input  logic        RST,
    input  logic        enable,
    input  logic [3:0]  chan_mask,
    input  logic [11:0] step,
    output logic [11:0] data,
    output logic [3:0]  address,
    output logic [3:0]  command,
    output logic        dactrig,
    input  logic        dacdone,
    output logic        busy,
    output logic        overrun,
    output logic        error,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SCAN      = 3'd1,
        TRIG      = 3'd2,
        WAIT_DONE = 3'd3,
        ADVANCE   = 3'd4
    } state_t;

    localparam int unsigned CW = $clog2(PERIOD);
    localparam logic [CW-1:0] TICK_LAST = CW'(PERIOD - 1);

    state_t        state;
    state_t        state_n;

    logic [CW-1:0] tick_cnt;
    logic          tick;

    logic [3:0]    mask;
    logic [1:0]    ch;
    logic [11:0]   ramp [4];
    logic          higher;

    // FSM strobes towards the datapath
    logic          do_latch;     // sweep start: capture mask, ch <= 0
    logic          do_load;      // channel hit: load data/address/command
    logic          do_inc_ch;    // move on to the next channel
    logic          do_adv;       // write completed: advance ramp[ch]
    logic          do_end;       // sweep finished normally
    logic          timeout_hit;  // WAIT_DONE expired (timeout build only)

    // -------------------------------------------------------------------------
    // Driver handshake: dactrig is a single-cycle request, asserted only in
    // TRIG. data/address/command are loaded on the cycle before TRIG and are
    // not touched again until the next channel hit, so they stay stable from
    // TRIG until the driver's dacdone has been taken. dacdone is a
    // single-cycle acknowledge and is honoured only in WAIT_DONE; a pulse in
    // any other state (including TRIG itself) is dropped.
    // -------------------------------------------------------------------------

    // Sweep tick: asserted on the last count of each period while enabled.
    assign tick = enable && (tick_cnt == TICK_LAST);

    // Any mask bit set above the current channel?
    always_comb begin
        case (ch)
            2'd0:    higher = |mask[3:1];
            2'd1:    higher = |mask[3:2];
            2'd2:    higher = mask[3];
            default: higher = 1'b0;
        endcase
    end

`ifdef DAC_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] wait_cnt;
    logic          error_q;
`else
    // TIMEOUT has no effect in this build.
    if (TIMEOUT == 0) begin : g_timeout_unused
    end
`endif

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and strobes
    // -------------------------------------------------------------------------
    always_comb begin
        state_n     = state;
        dactrig     = 1'b0;
        do_latch    = 1'b0;
        do_load     = 1'b0;
        do_inc_ch   = 1'b0;
        do_adv      = 1'b0;
        do_end      = 1'b0;
        timeout_hit = 1'b0;

        case (state)
            IDLE: begin
                if (tick && (chan_mask != 4'd0)) begin
                    do_latch = 1'b1;
                    state_n  = SCAN;
                end
            end

            SCAN: begin
                // Losing enable before any write was issued ends the sweep.
                if (!enable) begin
                    do_end  = 1'b1;
                    state_n = IDLE;
                end else if (mask[ch]) begin
                    do_load = 1'b1;
                    state_n = TRIG;
                end else if (ch == 2'd3) begin
                    do_end  = 1'b1;
                    state_n = IDLE;
                end else begin
                    do_inc_ch = 1'b1;
                end
            end

            TRIG: begin
                dactrig = 1'b1;
                state_n = WAIT_DONE;
            end

            WAIT_DONE: begin
                if (dacdone) begin
                    state_n = ADVANCE;
                end
`ifdef DAC_SEQ_TIMEOUT_EN
                else if (wait_cnt == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    state_n     = IDLE;
                end
`endif
            end

            ADVANCE: begin
                do_adv = 1'b1;
                // A dropped enable lets the current write finish, then stops.
                if (!enable || (ch == 2'd3) || !higher) begin
                    do_end  = 1'b1;
                    state_n = IDLE;
                end else begin
                    do_inc_ch = 1'b1;
                    state_n   = SCAN;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: tick counter, channel index, ramps, driver outputs, flags
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            tick_cnt <= '0;
            mask     <= '0;
            ch       <= '0;
            data     <= '0;
            address  <= '0;
            command  <= '0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                ramp[i] <= '0;
            end
        end else begin
            if (!enable || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + CW'(1);
            end

            if (do_latch) begin
                mask <= chan_mask;
                ch   <= 2'd0;
            end else if (do_inc_ch) begin
                ch <= ch + 2'd1;
            end

            if (do_load) begin
                data    <= ramp[ch];
                address <= {2'b00, ch};
                command <= CMD;
            end

            // Modulo-4096 wrap is the natural 12-bit overflow.
            if (do_adv) begin
                ramp[ch] <= ramp[ch] + step;
            end

            // busy rises together with the TRIG state.
            if (do_load) begin
                busy <= 1'b1;
            end else if (do_end || timeout_hit) begin
                busy <= 1'b0;
            end

            // tick already implies enable, so the clear never races the set.
            if (!enable) begin
                overrun <= 1'b0;
            end else if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef DAC_SEQ_TIMEOUT_EN
    // Wait counter restarts on every entry into WAIT_DONE (cleared in TRIG).
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            wait_cnt <= '0;
            error_q  <= 1'b0;
        end else begin
            if (state == TRIG) begin
                wait_cnt <= '0;
            end else if (state == WAIT_DONE) begin
                wait_cnt <= wait_cnt + TW'(1);
            end

            if (!enable) begin
                error_q <= 1'b0;
            end else if (timeout_hit) begin
                error_q <= 1'b1;
            end
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign state_dbg = state;

endmodule

// File: doc/dac_sequencer.md
Name: dac_sequencer

Overview:
- Upstream control stage for the SPI DAC driver; it drives that driver's data/address/command/dactrig inputs and consumes its dacdone.
- Issues a periodic sweep of DAC writes across up to 4 channels, one write per enabled channel per sweep.
- Each channel's value is an independent 12-bit sawtooth ramp.
- One write in flight at a time; the next write starts only after the driver reports done.

Parameters:
- PERIOD, 5000: CLK50MHZ cycles between sweep ticks (min 16).
- CMD, 4'b0011: command nibble sent with every write (write and update channel).
- TIMEOUT, 2048: max cycles to wait for dacdone. Used only with DAC_SEQ_TIMEOUT_EN.

Ports:
- CLK50MHZ  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- enable  in  1  run sweeps while high.
- chan_mask  in  4  bit n set = channel n written each sweep.
- step  in  12  ramp increment added after each completed write.
- data  out  12  sample for the driver.
- address  out  4  channel number, 0..3.
- command  out  4  always CMD during a write.
- dactrig  out  1  one-cycle start pulse to the driver.
- dacdone  in  1  one-cycle completion pulse from the driver.
- busy  out  1  high from the trig cycle until the sweep ends.
- overrun  out  1  sticky; a tick occurred while busy.
- error  out  1  sticky timeout flag.

Behaviour:
- Reset (RST low, async): all outputs 0, ramps[0..3]=0, tick counter=0, state IDLE.
- Tick counter:
  - Counts 0..PERIOD-1 while enable=1; tick asserts at PERIOD-1, then the counter wraps to 0.
  - Held at 0 while enable=0.
- States: IDLE, SCAN, TRIG, WAIT_DONE, ADVANCE.
- IDLE:
  - On tick with enable=1 and chan_mask!=0: latch chan_mask into an internal mask, set ch=0, go to SCAN.
  - On tick with chan_mask=0: no action.
- SCAN (one cycle per channel examined):
  - If mask[ch]=1: data<=ramp[ch], address<=ch, command<=CMD, go to TRIG.
  - Else if ch=3: go to IDLE.
  - Else: ch<=ch+1.
- TRIG:
  - dactrig=1 for exactly this cycle; busy<=1; go to WAIT_DONE.
  - data/address/command stay stable from TRIG through the cycle dacdone is sampled.
- WAIT_DONE:
  - dacdone is sampled only here, so dacdone in the TRIG cycle or in any other state is ignored.
  - On dacdone go to ADVANCE.
- ADVANCE:
  - ramp[ch] <= (ramp[ch]+step) mod 4096; the wrap is silent.
  - If ch=3 or no higher mask bit is set: busy<=0, go to IDLE. Otherwise ch<=ch+1 and go to SCAN.
- Latency: tick to first dactrig is at most 5 cycles (mask bit 3 only: IDLE→SCAN×4→TRIG).
- Tick while not IDLE: the tick is dropped and overrun is set.
- overrun and error clear only when enable=0 (synchronous clear) or on reset.
- enable deasserted mid-sweep:
  - The current transaction completes (WAIT_DONE still waits for dacdone) and its ramp still advances.
  - The FSM then returns to IDLE without scanning further channels.
- chan_mask changes mid-sweep take effect at the next sweep.
- step is sampled in ADVANCE.
- data/address/command hold their last values in IDLE.

Optional Feature:
- DAC_SEQ_TIMEOUT_EN defined:
  - A wait counter runs in WAIT_DONE, cleared on entry.
  - If it reaches TIMEOUT before dacdone: error<=1, ramp not advanced, busy<=0, go to IDLE (sweep abandoned).
  - A later stray dacdone is ignored.
- DAC_SEQ_TIMEOUT_EN undefined:
  - No counter; WAIT_DONE waits indefinitely.
  - error is tied to 0; the TIMEOUT parameter is unused.

Test Plan:
- RST low mid-WAIT_DONE: outputs, ramps and state return to 0/IDLE immediately (asynchronous); after release, the first dactrig comes only after a full PERIOD.
- PERIOD=16, mask=4'b0101, step=100, dacdone 20 cycles after each dactrig:
  - Sweep 1 writes (addr0, 0), then (addr2, 0).
  - Sweep 2 writes (addr0, 100), then (addr2, 100).
  - command=0011 on every write.
- step=12'hFFF, mask=4'b0001, 3 sweeps: data sequence 0x000, 0xFFF, 0xFFE (wrap verified).
- dacdone withheld for 40 cycles with PERIOD=16: ticks dropped, overrun=1, no second dactrig until dacdone; overrun clears after enable=0.
- dacdone pulsed in the TRIG cycle and in IDLE: ignored, FSM stays in WAIT_DONE/IDLE.
- DAC_SEQ_TIMEOUT_EN, TIMEOUT=8, dacdone never sent: error=1 exactly 8 cycles after entering WAIT_DONE, ramp unchanged, FSM in IDLE. Without the macro, error stays 0 and the FSM stays in WAIT_DONE.
